// File: rtl/draw_sprite_anim_pkg.sv
// Shared widths, sprite geometry and the delay-line payload for the sprite overlay stage.
package draw_sprite_anim_pkg;

    localparam int unsigned HCNT_W        = 11;
    localparam int unsigned RGB_W         = 12;
    localparam int unsigned SPRITE_W      = 32;
    localparam int unsigned SPRITE_H      = 32;
    localparam int unsigned SPRITE_FRAMES = 4;
    localparam int unsigned SPR_AW        = $clog2(SPRITE_W);
    localparam int unsigned FRM_W         = $clog2(SPRITE_FRAMES);
    localparam int unsigned ADDR_W        = FRM_W + 2 * SPR_AW;

    // Everything that must stay aligned with the sprite ROM read.
    typedef struct packed {
        logic [HCNT_W-1:0] hcount;
        logic              hsync;
        logic              hblnk;
        logic [HCNT_W-1:0] vcount;
        logic              vsync;
        logic              vblnk;
        logic [RGB_W-1:0]  rgb;
        logic              hit;
    } pix_t;

endpackage

// File: rtl/draw_sprite_anim_if.sv
// VGA pixel stream: timing counters, syncs, blanks and colour.
interface draw_sprite_anim_if;
    import draw_sprite_anim_pkg::*;

    logic [HCNT_W-1:0] hcount;
    logic [HCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/draw_sprite_anim_delay.sv
// Fixed-length register delay line with synchronous clear.
module draw_sprite_anim_delay #(
    parameter int unsigned WIDTH   = 39,
    parameter int unsigned CLK_DEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] pipe_q [CLK_DEL];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CLK_DEL; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= din_i;
            for (int unsigned i = 1; i < CLK_DEL; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout_o = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_sprite_anim.sv
// Overlays one animated, optionally mirrored 32x32 sprite on the VGA stream.
// Position/mirror/enable are latched on vblank rise so a frame never tears.
module draw_sprite_anim
    import draw_sprite_anim_pkg::*;
#(
    parameter int unsigned      FRAME_DIV   = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT = 12'hF0F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [HCNT_W-1:0]  xpos,
    input  logic [HCNT_W-1:0]  ypos,
    input  logic               mirror,
    input  logic [RGB_W-1:0]   rgb_pixel,
    output logic [ADDR_W-1:0]  pixel_addr,
    draw_sprite_anim_if.in     in,
    draw_sprite_anim_if.out    out
);

    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic              vblnk_prev_q;
    logic [HCNT_W-1:0] x_lat_q, x_lat_d, y_lat_q, y_lat_d;
    logic              mir_lat_q, mir_lat_d, en_lat_q, en_lat_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [FRM_W-1:0]  anim_frame_q, anim_frame_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              vb_rise;
    logic [HCNT_W-1:0] dx, dy;
    logic [SPR_AW-1:0] col;
    logic              hit;
    pix_t              line_in, line_out;
    logic [RGB_W-1:0]  rgb_d;

    assign vb_rise = in.vblnk & ~vblnk_prev_q;
    assign dx      = in.hcount - x_lat_q;
    assign dy      = in.vcount - y_lat_q;
    // Unsigned wrap turns columns/rows left of or above the sprite into misses.
    assign hit     = en_lat_q && !in.hblnk && !in.vblnk &&
                     (dx < HCNT_W'(SPRITE_W)) && (dy < HCNT_W'(SPRITE_H));
    assign col     = mir_lat_q ? ~dx[SPR_AW-1:0] : dx[SPR_AW-1:0];

    // Frame latch, animation divider and ROM address.
    always_comb begin
        x_lat_d      = x_lat_q;
        y_lat_d      = y_lat_q;
        mir_lat_d    = mir_lat_q;
        en_lat_d     = en_lat_q;
        div_cnt_d    = div_cnt_q;
        anim_frame_d = anim_frame_q;
        addr_d       = addr_q;

        if (vb_rise) begin
            x_lat_d   = xpos;
            y_lat_d   = ypos;
            mir_lat_d = mirror;
            en_lat_d  = enable;
        end

        if (!en_lat_q) begin
            div_cnt_d    = '0;
            anim_frame_d = '0;
        end else if (vb_rise) begin
            if (div_cnt_q == DIV_W'(FRAME_DIV - 1)) begin
                div_cnt_d    = '0;
                anim_frame_d = anim_frame_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end

        if (hit) addr_d = {anim_frame_q, dy[SPR_AW-1:0], col};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            x_lat_q      <= '0;
            y_lat_q      <= '0;
            mir_lat_q    <= 1'b0;
            en_lat_q     <= 1'b0;
            div_cnt_q    <= '0;
            anim_frame_q <= '0;
            addr_q       <= '0;
        end else begin
            vblnk_prev_q <= in.vblnk;
            x_lat_q      <= x_lat_d;
            y_lat_q      <= y_lat_d;
            mir_lat_q    <= mir_lat_d;
            en_lat_q     <= en_lat_d;
            div_cnt_q    <= div_cnt_d;
            anim_frame_q <= anim_frame_d;
            addr_q       <= addr_d;
        end
    end

    assign pixel_addr = addr_q;

    always_comb begin
        line_in        = '0;
        line_in.hcount = in.hcount;
        line_in.hsync  = in.hsync;
        line_in.hblnk  = in.hblnk;
        line_in.vcount = in.vcount;
        line_in.vsync  = in.vsync;
        line_in.vblnk  = in.vblnk;
        line_in.rgb    = in.rgb;
        line_in.hit    = hit;
    end

    draw_sprite_anim_delay #(
        .WIDTH   ($bits(pix_t)),
        .CLK_DEL (2)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .din_i  (line_in),
        .dout_o (line_out)
    );

    // ROM data lands together with the delay-line output.
    always_comb begin
        rgb_d = line_out.rgb;
        if (!(line_out.vblnk || line_out.hblnk) && line_out.hit && (rgb_pixel != TRANSPARENT))
            rgb_d = rgb_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= line_out.hcount;
            out.vcount <= line_out.vcount;
            out.hsync  <= line_out.hsync;
            out.vsync  <= line_out.vsync;
            out.hblnk  <= line_out.hblnk;
            out.vblnk  <= line_out.vblnk;
            out.rgb    <= rgb_d;
        end
    end

endmodule

// File: tb/tb_draw_sprite_anim.sv
// Randomized raster stimulus for draw_sprite_anim checked against a frame-level reference model.
module tb_draw_sprite_anim;
    import draw_sprite_anim_pkg::*;

    localparam int unsigned FRAME_DIV = 8;
    localparam logic [11:0] TRANSP    = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [10:0] xpos, ypos;
    logic        mirror;
    logic [11:0] rgb_pixel;
    logic [11:0] pixel_addr;

    always #5 clk = ~clk;

    draw_sprite_anim_if vin ();
    draw_sprite_anim_if vout ();

    draw_sprite_anim #(
        .FRAME_DIV   (FRAME_DIV),
        .TRANSPARENT (TRANSP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .xpos       (xpos),
        .ypos       (ypos),
        .mirror     (mirror),
        .rgb_pixel  (rgb_pixel),
        .pixel_addr (pixel_addr),
        .in         (vin),
        .out        (vout)
    );

    // Sprite ROM model: 0 = solid green, 1 = column 5 transparent, 2 = colour equals address.
    int rom_mode;

    function automatic logic [11:0] rom_data(input logic [11:0] a);
        case (rom_mode)
            0:       return 12'h0F0;
            1:       return (a[4:0] == 5'd5) ? 12'hF0F : 12'h0F0;
            default: return a;
        endcase
    endfunction

    always @(posedge clk) rgb_pixel <= rom_data(pixel_addr);

    typedef struct packed {
        logic [25:0] tim;
        logic [11:0] rgb;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] exp_addr;
    logic [10:0] m_x, m_y;
    logic        m_mir, m_en, m_prev_vb;
    int          m_n;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, act, expv, $time);
        end
    endtask

    // One pixel clock: check what the DUT shows now, then drive the next pixel and predict it.
    task automatic cycle(input logic r, input logic [10:0] hc, input logic [10:0] vc,
                         input logic hs, input logic vs, input logic hb, input logic vb,
                         input logic [11:0] rgb, input logic en, input logic [10:0] x,
                         input logic [10:0] y, input logic mir);
        exp_t        e;
        logic [10:0] dx, dy;
        logic [4:0]  col;
        logic [11:0] a;
        logic        hit;
        int          frm;

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("timing", 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}),
              32'(e.tim));
        check("rgb", 32'(vout.rgb), 32'(e.rgb));
        check("pixel_addr", 32'(pixel_addr), 32'(exp_addr));

        rst = r; vin.hcount = hc; vin.vcount = vc; vin.hsync = hs; vin.vsync = vs;
        vin.hblnk = hb; vin.vblnk = vb; vin.rgb = rgb;
        enable = en; xpos = x; ypos = y; mirror = mir;

        if (r) begin
            foreach (exp_q[i]) exp_q[i] = '0;
            exp_q.push_back('0);
            exp_addr = '0;
            m_x = '0; m_y = '0; m_mir = 1'b0; m_en = 1'b0; m_prev_vb = 1'b0; m_n = 0;
        end else begin
            dx    = hc - m_x;
            dy    = vc - m_y;
            hit   = m_en && !hb && !vb && (dx < 11'd32) && (dy < 11'd32);
            e.tim = {hc, vc, hs, vs, hb, vb};
            e.rgb = rgb;
            if (hit) begin
                frm      = (m_n / int'(FRAME_DIV)) % 4;
                col      = m_mir ? 5'(31 - int'(dx[4:0])) : dx[4:0];
                a        = 12'(frm * 1024 + int'(dy[4:0]) * 32 + int'(col));
                exp_addr = a;
                if (rom_data(a) != TRANSP) e.rgb = rom_data(a);
            end
            exp_q.push_back(e);
            if (vb && !m_prev_vb) begin
                if (m_en) m_n++;
                m_x = x; m_y = y; m_mir = mir; m_en = en;
                if (!m_en) m_n = 0;
            end
            m_prev_vb = vb;
        end
    endtask

    // One raster: visible rows first, then vblank rows where the next frame's sprite state is driven.
    task automatic run_frame(input int h_org, input int v_org, input int h_vis, input int h_tot,
                             input int v_vis, input int v_tot, input logic [10:0] nx,
                             input logic [10:0] ny, input logic nmir, input logic nen,
                             input bit jitter, input int rst_at);
        for (int v = 0; v < v_tot; v++) begin
            for (int h = 0; h < h_tot; h++) begin
                int   idx;
                logic r, hb, vb;
                idx = v * h_tot + h;
                r   = (rst_at >= 0) && (idx >= rst_at) && (idx < rst_at + 2);
                hb  = (h >= h_vis);
                vb  = (v >= v_vis);
                if (vb || !jitter)
                    cycle(r, 11'(h_org + h), 11'(v_org + v), h == h_vis + 1, v == v_vis + 1,
                          hb, vb, 12'($urandom), nen, nx, ny, nmir);
                else
                    cycle(r, 11'(h_org + h), 11'(v_org + v), h == h_vis + 1, v == v_vis + 1,
                          hb, vb, 12'($urandom), 1'($urandom), 11'($urandom), 11'($urandom),
                          1'($urandom));
            end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; xpos = '0; ypos = '0; mirror = 1'b0;
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        rom_mode = 0; n_checks = 0; n_errors = 0;
        m_x = '0; m_y = '0; m_mir = 1'b0; m_en = 1'b0; m_prev_vb = 1'b0; m_n = 0;
        exp_addr = '0;
        repeat (3) exp_q.push_back('0);

        // Reset held with toggling inputs.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 12'($urandom), 1'b1, 11'd100, 11'd200, 1'b0);

        // Frame 0 shows no sprite; then placement at (100,200) with mid-frame input noise.
        run_frame(96, 196, 40, 44, 40, 43, 11'd100, 11'd200, 1'b0, 1'b1, 1'b0, -1);
        run_frame(96, 196, 40, 44, 40, 43, 11'd100, 11'd200, 1'b0, 1'b1, 1'b1, -1);

        // Transparent column 5; next frame mirrored at the left edge.
        rom_mode = 1;
        run_frame(96, 196, 40, 44, 40, 43, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, -1);
        rom_mode = 2;
        run_frame(0, 0, 40, 44, 36, 40, 11'd1270, 11'd4, 1'b0, 1'b1, 1'b0, -1);

        // Right-edge clip, then a reset pulse in the middle of a frame.
        run_frame(1250, 0, 30, 34, 40, 43, 11'd100, 11'd200, 1'b0, 1'b1, 1'b1, -1);
        run_frame(96, 196, 40, 44, 40, 43, 11'd2, 11'd1, 1'b0, 1'b1, 1'b0, 500);

        // Animation sequencing over many short frames, then disabled.
        run_frame(96, 196, 40, 44, 40, 43, 11'd2, 11'd1, 1'b0, 1'b1, 1'b0, -1);
        for (int f = 0; f < 40; f++)
            run_frame(0, 0, 8, 10, 4, 6, 11'd2, 11'd1, 1'b0, 1'b1, 1'b0, -1);
        for (int f = 0; f < 3; f++)
            run_frame(0, 0, 8, 10, 4, 6, 11'd2, 11'd1, 1'b0, 1'b0, 1'b0, -1);
        run_frame(0, 0, 8, 10, 4, 6, 11'd100, 11'd200, 1'b1, 1'b1, 1'b0, -1);

        // Random placements, mirrors, enables and ROM patterns.
        for (int f = 0; f < 6; f++) begin
            rom_mode = int'($urandom_range(0, 2));
            run_frame(96, 196, 40, 44, 40, 43, 11'($urandom_range(80, 140)),
                      11'($urandom_range(180, 240)), 1'($urandom), ($urandom_range(0, 3) != 0),
                      1'b1, -1);
        end

        for (int i = 0; i < 4; i++)
            cycle(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 11'd0, 11'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
